// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Brief    : ID->EX holding register with operand select and RAW hazard
//            resolution. Define FORWARDING_EN to enable EX/MEM and MEM/WB bypass.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALU_OPW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [REG_AW-1:0]  in_rs1,
  input  logic [REG_AW-1:0]  in_rs2,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [1:0]         in_a_sel,
  input  logic               in_b_sel,
  input  logic [ALU_OPW-1:0] in_alu_op,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_rd_we,
  input  logic [REG_AW-1:0]  exmem_rd,
  input  logic               exmem_we,
  input  logic               exmem_is_load,
  input  logic [XLEN-1:0]    exmem_data,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic               wb_we,
  input  logic [XLEN-1:0]    wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    operand_a,
  output logic [XLEN-1:0]    operand_b,
  output logic [ALU_OPW-1:0] alu_op,
  output logic [REG_AW-1:0]  out_rd,
  output logic               out_rd_we,
  output logic [XLEN-1:0]    out_rs2_val
);

  logic               r_held_valid;
  logic [XLEN-1:0]    r_pc;
  logic [REG_AW-1:0]  r_rs1;
  logic [REG_AW-1:0]  r_rs2;
  logic [XLEN-1:0]    r_rs1_data;
  logic [XLEN-1:0]    r_rs2_data;
  logic [XLEN-1:0]    r_imm;
  logic [1:0]         r_a_sel;
  logic               r_b_sel;
  logic [ALU_OPW-1:0] r_alu_op;
  logic [REG_AW-1:0]  r_rd;
  logic               r_rd_we;

  logic            w_rs1_used;
  logic            w_ex_hit1, w_ex_hit2;
  logic            w_wb_hit1, w_wb_hit2;
  logic            w_wb_cap1, w_wb_cap2;
  logic            w_hazard;
  logic            w_capture;
  logic            w_fire;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  assign w_rs1_used = (r_a_sel == 2'b00) || (r_a_sel == 2'b11);

  // x0 never matches a writer, so every hit requires a nonzero source
  assign w_ex_hit1 = exmem_we && (exmem_rd == r_rs1) && (r_rs1 != '0);
  assign w_ex_hit2 = exmem_we && (exmem_rd == r_rs2) && (r_rs2 != '0);
  assign w_wb_hit1 = wb_we && (wb_rd == r_rs1) && (r_rs1 != '0);
  assign w_wb_hit2 = wb_we && (wb_rd == r_rs2) && (r_rs2 != '0);
  assign w_wb_cap1 = wb_we && (wb_rd == in_rs1) && (in_rs1 != '0);
  assign w_wb_cap2 = wb_we && (wb_rd == in_rs2) && (in_rs2 != '0);

`ifdef FORWARDING_EN
  assign w_hazard  = r_held_valid && exmem_is_load && ((w_rs1_used && w_ex_hit1) || w_ex_hit2);
  assign w_rs1_val = (w_ex_hit1 && !exmem_is_load) ? exmem_data :
                     w_wb_hit1                     ? wb_data    : r_rs1_data;
  assign w_rs2_val = (w_ex_hit2 && !exmem_is_load) ? exmem_data :
                     w_wb_hit2                     ? wb_data    : r_rs2_data;
`else
  // Without bypass the entry also waits out the cycle in which the snoop refreshes it
  assign w_hazard  = r_held_valid &&
                     ((w_rs1_used && (w_ex_hit1 || w_wb_hit1)) || w_ex_hit2 || w_wb_hit2);
  assign w_rs1_val = r_rs1_data;
  assign w_rs2_val = r_rs2_data;
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_data, exmem_is_load};
`endif

  assign out_valid = r_held_valid && !w_hazard;
  assign in_ready  = flush || !r_held_valid || (out_ready && !w_hazard);
  assign w_capture = in_valid && in_ready && !flush;
  assign w_fire    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held_valid <= 1'b0;
      r_pc         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_a_sel      <= '0;
      r_b_sel      <= 1'b0;
      r_alu_op     <= '0;
      r_rd         <= '0;
      r_rd_we      <= 1'b0;
    end else if (flush) begin
      r_held_valid <= 1'b0;
    end else if (w_capture) begin
      r_held_valid <= 1'b1;
      r_pc         <= in_pc;
      r_rs1        <= in_rs1;
      r_rs2        <= in_rs2;
      r_rs1_data   <= (in_rs1 == '0) ? '0 : (w_wb_cap1 ? wb_data : in_rs1_data);
      r_rs2_data   <= (in_rs2 == '0) ? '0 : (w_wb_cap2 ? wb_data : in_rs2_data);
      r_imm        <= in_imm;
      r_a_sel      <= in_a_sel;
      r_b_sel      <= in_b_sel;
      r_alu_op     <= in_alu_op;
      r_rd         <= in_rd;
      r_rd_we      <= in_rd_we;
    end else begin
      if (w_fire)
        r_held_valid <= 1'b0;
      if (r_held_valid && w_wb_hit1)
        r_rs1_data <= wb_data;
      if (r_held_valid && w_wb_hit2)
        r_rs2_data <= wb_data;
    end
  end

  always_comb begin
    operand_a = w_rs1_val;
    case (r_a_sel)
      2'b01:   operand_a = r_pc;
      2'b10:   operand_a = '0;
      default: operand_a = w_rs1_val;
    endcase
  end

  assign operand_b   = r_b_sel ? r_imm : w_rs2_val;
  assign alu_op      = r_alu_op;
  assign out_rd      = r_rd;
  assign out_rd_we   = r_rd_we;
  assign out_rs2_val = w_rs2_val;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Brief    : Directed self-checking bench for ex_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic [1:0]  in_a_sel;
  logic        in_b_sel;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [4:0]  exmem_rd;
  logic        exmem_we, exmem_is_load;
  logic [31:0] exmem_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_rs2_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_is_load(exmem_is_load),
    .exmem_data(exmem_data), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a),
    .operand_b(operand_b), .alu_op(alu_op), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_rs2_val(out_rs2_val)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_a_sel = 0; in_b_sel = 0;
    in_alu_op = 0; in_rd = 0; in_rd_we = 0;
    exmem_rd = 0; exmem_we = 0; exmem_is_load = 0; exmem_data = 0;
    wb_rd = 0; wb_we = 0; wb_data = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic [1:0] asel, input logic bsel,
                             input logic [3:0] op, input logic [4:0] rd, input logic we);
    in_valid = 1; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_pc = pc; in_imm = imm; in_a_sel = asel; in_b_sel = bsel;
    in_alu_op = op; in_rd = rd; in_rd_we = we;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 0;
    clear_inputs();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    checks++; if (operand_a !== 32'h0 || operand_b !== 32'h0) begin errors++; $display("FAIL rst_ops: got a=%0h b=%0h want 0 0", operand_a, operand_b); end
    checks++; if (alu_op !== 4'h0 || out_rd !== 5'h0 || out_rd_we !== 1'b0) begin errors++; $display("FAIL rst_pass: got op=%0h rd=%0h we=%0b want 0", alu_op, out_rd, out_rd_we); end
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_capture();
    out_ready = 1;
    drive_instr(5'd1, 32'd5, 5'd0, 32'd0, 32'h100, 32'd7, 2'b00, 1'b1, 4'd0, 5'd4, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cap_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cap_valid: got %0b want 1", out_valid); end
    checks++; if (operand_a !== 32'd5 || operand_b !== 32'd7 || alu_op !== 4'd0) begin errors++; $display("FAIL cap_ops: got a=%0h b=%0h op=%0h want 5 7 0", operand_a, operand_b, alu_op); end
    checks++; if (out_rd !== 5'd4 || out_rd_we !== 1'b1) begin errors++; $display("FAIL cap_rd: got rd=%0h we=%0b want 4 1", out_rd, out_rd_we); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_exmem_hazard();
    out_ready = 1;
    drive_instr(5'd2, 32'h11, 5'd0, 32'd0, 32'h0, 32'd3, 2'b00, 1'b1, 4'd1, 5'd6, 1'b1);
    tick();
    in_valid = 0;
    exmem_rd = 5'd2; exmem_we = 1; exmem_data = 32'h55; exmem_is_load = 0;
    #1;
`ifdef FORWARDING_EN
    checks++; if (out_valid !== 1'b1 || operand_a !== 32'h55) begin errors++; $display("FAIL fwd_exmem: got v=%0b a=%0h want 1 55", out_valid, operand_a); end
    tick();
    exmem_we = 0;
`else
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_exmem: got v=%0b rdy=%0b want 0 0", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_hold: got %0b want 0", out_valid); end
    exmem_we = 0;
    wb_rd = 5'd2; wb_we = 1; wb_data = 32'h55;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_wb: got %0b want 0", out_valid); end
    tick();
    wb_we = 0;
    #1;
    checks++; if (out_valid !== 1'b1 || operand_a !== 32'h55) begin errors++; $display("FAIL snoop_exmem: got v=%0b a=%0h want 1 55", out_valid, operand_a); end
    tick();
`endif
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exmem_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_load_use();
    out_ready = 1;
    drive_instr(5'd3, 32'h1, 5'd0, 32'd0, 32'h0, 32'd0, 2'b00, 1'b1, 4'd0, 5'd7, 1'b1);
    tick();
    in_valid = 0;
    exmem_rd = 5'd3; exmem_we = 1; exmem_is_load = 1; exmem_data = 32'hDEAD;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL load_stall: got v=%0b rdy=%0b want 0 0", out_valid, in_ready); end
    tick();
    exmem_we = 0; exmem_is_load = 0;
    wb_rd = 5'd3; wb_we = 1; wb_data = 32'h9;
    #1;
`ifdef FORWARDING_EN
    checks++; if (out_valid !== 1'b1 || operand_a !== 32'h9) begin errors++; $display("FAIL load_wbfwd: got v=%0b a=%0h want 1 9", out_valid, operand_a); end
    tick();
    wb_we = 0;
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_wbwait: got %0b want 0", out_valid); end
    tick();
    wb_we = 0;
    #1;
    checks++; if (out_valid !== 1'b1 || operand_a !== 32'h9) begin errors++; $display("FAIL load_snoop: got v=%0b a=%0h want 1 9", out_valid, operand_a); end
    tick();
`endif
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive_instr(5'd5, 32'h100, 5'd6, 32'h22, 32'h40, 32'd0, 2'b01, 1'b0, 4'd2, 5'd10, 1'b1);
    tick();
    drive_instr(5'd9, 32'h7, 5'd11, 32'h33, 32'h80, 32'h1234, 2'b10, 1'b1, 4'd9, 5'd12, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_ready: got rdy=%0b v=%0b want 0 1", in_ready, out_valid); end
    checks++; if (operand_a !== 32'h40 || operand_b !== 32'h22 || alu_op !== 4'd2) begin errors++; $display("FAIL bp_ops: got a=%0h b=%0h op=%0h want 40 22 2", operand_a, operand_b, alu_op); end
    tick();
    checks++; if (in_ready !== 1'b0 || operand_a !== 32'h40 || out_rd !== 5'd10) begin errors++; $display("FAIL bp_stable: got rdy=%0b a=%0h rd=%0h want 0 40 a", in_ready, operand_a, out_rd); end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b want 1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b1 || operand_a !== 32'h0 || operand_b !== 32'h1234) begin errors++; $display("FAIL b2b_ops: got v=%0b a=%0h b=%0h want 1 0 1234", out_valid, operand_a, operand_b); end
    checks++; if (alu_op !== 4'd9 || out_rs2_val !== 32'h33 || out_rd !== 5'd12 || out_rd_we !== 1'b0) begin errors++; $display("FAIL b2b_pass: got op=%0h rs2=%0h rd=%0h we=%0b want 9 33 c 0", alu_op, out_rs2_val, out_rd, out_rd_we); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_wb_snoop();
    out_ready = 0;
    drive_instr(5'd0, 32'd0, 5'd4, 32'hAAAA, 32'h0, 32'h0, 2'b10, 1'b0, 4'd3, 5'd1, 1'b1);
    wb_rd = 5'd4; wb_we = 1; wb_data = 32'hBEEF;
    tick();
    in_valid = 0; wb_we = 0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_rs2_val !== 32'hBEEF || operand_b !== 32'hBEEF) begin errors++; $display("FAIL snoop_cap: got v=%0b rs2=%0h b=%0h want 1 beef beef", out_valid, out_rs2_val, operand_b); end
    wb_rd = 5'd4; wb_we = 1; wb_data = 32'hC0DE;
    tick();
    wb_we = 0;
    #1;
    checks++; if (out_valid !== 1'b1 || operand_b !== 32'hC0DE) begin errors++; $display("FAIL snoop_hold: got v=%0b b=%0h want 1 c0de", out_valid, operand_b); end
    out_ready = 1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive_instr(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 32'h0, 2'b00, 1'b0, 4'd4, 5'd3, 1'b1);
    tick();
    drive_instr(5'd4, 32'h4, 5'd5, 32'h5, 32'h0, 32'h0, 2'b00, 1'b0, 4'd6, 5'd7, 1'b1);
    flush = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_drop: got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_x0_and_async_reset();
    out_ready = 0;
    drive_instr(5'd0, 32'h33, 5'd7, 32'h44, 32'h0, 32'h12, 2'b00, 1'b1, 4'd5, 5'd8, 1'b1);
    exmem_rd = 5'd0; exmem_we = 1; exmem_data = 32'hFF; exmem_is_load = 0;
    tick();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b1 || operand_a !== 32'h0 || operand_b !== 32'h12) begin errors++; $display("FAIL x0_ops: got v=%0b a=%0h b=%0h want 1 0 12", out_valid, operand_a, operand_b); end
    exmem_rd = 5'd7; exmem_is_load = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b want 0", out_valid); end
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || operand_a !== 32'h0 || operand_b !== 32'h0) begin errors++; $display("FAIL arst_ops: got v=%0b a=%0h b=%0h want 0 0 0", out_valid, operand_a, operand_b); end
    checks++; if (alu_op !== 4'h0 || out_rd !== 5'h0 || out_rd_we !== 1'b0 || out_rs2_val !== 32'h0) begin errors++; $display("FAIL arst_pass: got op=%0h rd=%0h we=%0b rs2=%0h want 0", alu_op, out_rd, out_rd_we, out_rs2_val); end
    clear_inputs();
    tick();
    rst_n = 1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_after: got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_exmem_hazard();
    test_load_use();
    test_back_to_back();
    test_wb_snoop();
    test_flush();
    test_x0_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
